// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding instruction fetches and
// holds the IF/ID pipeline register presented to decode.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_PC  = XLEN'('h100),
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pcSel,
  input  logic            pcStall,
  input  logic            ifidStall,
  input  logic            instNop,
  input  logic [XLEN-1:0] branchTarget,
  input  logic [XLEN-1:0] jalrTarget,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic [31:0]     imemRdata,
  input  logic            imemValid,
  output logic [XLEN-1:0] dPc,
  output logic [XLEN-1:0] dPc4,
  output logic [31:0]     dInst,
  output logic            dValid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request in flight at pc
    HOLD  = 2'd1,  // response captured into ibuf, waiting for stall release
    DRAIN = 2'd2   // stale request in flight, its response is thrown away
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     inst;
    logic            valid;
  } ifid_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, pc_plus4, target;
  logic [31:0]     ibuf, ibuf_nx;
  ifid_t           ifid, ifid_nx, bubble;
  logic            outst;
  logic            stall, redirect;

  assign stall    = pcStall | ifidStall;
  assign redirect = (pcSel != 2'd0) & ~pcStall;
  assign pc_plus4 = pc + XLEN'(4);

  // a bubble keeps the last PC pair so dPc4 stays a sane link value
  assign bubble = '{pc: ifid.pc, pc4: ifid.pc4, inst: NOP_INST, valid: 1'b0};

  // real capture of the instruction at pc, optionally squashed to a bubble
  function automatic ifid_t capture(input logic [XLEN-1:0] p,
                                    input logic [XLEN-1:0] p4,
                                    input logic [31:0]     inst,
                                    input logic            nop);
    ifid_t r;
    r.pc    = p;
    r.pc4   = p4;
    r.inst  = nop ? NOP_INST : inst;
    r.valid = ~nop;
    return r;
  endfunction

  // next-PC mux; JALR sums have bit 0 dropped
  always_comb begin
    target = pc_plus4;
    case (pcSel)
      2'd1:    target = branchTarget;
      2'd2:    target = {jalrTarget[XLEN-1:1], 1'b0};
      2'd3:    target = TRAP_PC;
      default: target = pc_plus4;
    endcase
  end

  // fetch control: next state, next PC, buffer and IF/ID updates
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ibuf_nx  = ibuf;
    ifid_nx  = ifid;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nx   = target;
          ifid_nx = bubble;
          if (!imemValid) state_nx = DRAIN;
        end else if (imemValid && !stall) begin
          ifid_nx = capture(pc, pc_plus4, imemRdata, instNop);
          pc_nx   = pc_plus4;
        end else if (imemValid) begin
          ibuf_nx  = imemRdata;
          state_nx = HOLD;
        end else if (!ifidStall) begin
          ifid_nx = bubble;
        end
      end
      HOLD: begin
        if (redirect) begin
          ibuf_nx  = '0;
          pc_nx    = target;
          ifid_nx  = bubble;
          state_nx = FETCH;
        end else if (!stall) begin
          ifid_nx  = capture(pc, pc_plus4, ibuf, instNop);
          pc_nx    = pc_plus4;
          state_nx = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nx   = target;
          ifid_nx = bubble;
        end
        if (imemValid) state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // state registers; outst tracks an unanswered request across reset so a
  // reset in the middle of a fetch still swallows the late response
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      ifid  <= '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};
      ibuf  <= '0;
      state <= (outst && !imemValid) ? DRAIN : FETCH;
      outst <= outst & ~imemValid;
    end else begin
      pc    <= pc_nx;
      ifid  <= ifid_nx;
      ibuf  <= ibuf_nx;
      state <= state_nx;
      outst <= (outst | imemReq) & ~imemValid;
    end
  end

  assign imemReq  = (state == FETCH) & ~rst;
  assign imemAddr = pc;
  assign dPc      = ifid.pc;
  assign dPc4     = ifid.pc4;
  assign dInst    = ifid.inst;
  assign dValid   = ifid.valid;

endmodule
